// File: rtl/div_pkg.sv
// Shared types and constants for the iterative signed divider.
package div_pkg;

  localparam int unsigned DIV_ITER  = 32;
  localparam int unsigned DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage : div_pkg

// File: rtl/div_step.sv
// One restoring-division step on magnitudes: shift {rem, quo} left by one,
// then conditionally subtract the divisor and produce one quotient bit.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] babs_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   babs_ext;
  logic [WIDTH-1:0] quo_sh;

  assign rem_sh   = {rem_i[WIDTH-1:0], quo_i[WIDTH-1]};
  assign quo_sh   = {quo_i[WIDTH-2:0], 1'b0};
  assign babs_ext = {1'b0, babs_i};

  // Extra remainder bit keeps the shifted value from overflowing before the compare.
  always_comb begin
    rem_o = rem_sh;
    quo_o = quo_sh;
    if (rem_sh >= babs_ext) begin
      rem_o = rem_sh - babs_ext;
      quo_o = quo_sh | WIDTH'(1);
    end
  end

endmodule : div_step

// File: rtl/div_unit.sv
// Multi-cycle signed divider for MIPS div: quotient on lo, remainder on hi,
// one quotient bit per cycle on operand magnitudes with a final sign fix.
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam logic [DIV_CNT_W-1:0] LAST_CNT = DIV_CNT_W'(DIV_ITER - 1);

  div_state_t           state_q;
  logic [WIDTH:0]       rem_q;
  logic [WIDTH-1:0]     quo_q;
  logic [WIDTH-1:0]     babs_q;
  logic                 sign_q_q;
  logic                 sign_r_q;
  logic [DIV_CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0]     lo_q;
  logic [WIDTH-1:0]     hi_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 div_zero_q;

  logic [WIDTH:0]       rem_d;
  logic [WIDTH-1:0]     quo_d;
  logic [WIDTH-1:0]     a_abs_c;
  logic [WIDTH-1:0]     b_abs_c;

  // Magnitudes as unsigned; the most negative value maps to 2^(WIDTH-1) exactly.
  always_comb begin
    a_abs_c = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    b_abs_c = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .babs_i (babs_q),
    .rem_o  (rem_d),
    .quo_o  (quo_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      quo_q      <= '0;
      babs_q     <= '0;
      sign_q_q   <= 1'b0;
      sign_r_q   <= 1'b0;
      cnt_q      <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q     <= 1'b1;
            div_zero_q <= 1'b0;
            if (b != '0) begin
              quo_q    <= a_abs_c;
              babs_q   <= b_abs_c;
              rem_q    <= '0;
              cnt_q    <= '0;
              sign_q_q <= a[WIDTH-1] ^ b[WIDTH-1];
              sign_r_q <= a[WIDTH-1];
              state_q  <= RUN;
            end else begin
              state_q  <= DONE;
            end
          end
        end
        RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + DIV_CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          lo_q    <= sign_q_q ? (~quo_q + WIDTH'(1)) : quo_q;
          hi_q    <= sign_r_q ? (~rem_q[WIDTH-1:0] + WIDTH'(1)) : rem_q[WIDTH-1:0];
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          // Entry from FIX already raised done; entry from IDLE is the divide-by-zero path.
          if (done_q) begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            done_q     <= 1'b1;
            div_zero_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lo       = lo_q;
  assign hi       = hi_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;

endmodule : div_unit

// File: doc/div_unit.md
# div_unit

Multi-cycle signed 32-bit divider for the MIPS `div` instruction. It sits directly upstream of the LO/HI result muxes: `lo` carries the quotient into the div side of the LO mux, and `hi` carries the remainder into the HI mux. The control unit pulses `start` and waits for `done` before writing HI/LO. Division is iterative restoring, one quotient bit per cycle, with sign correction at the end.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width. Must be 32 for this CPU; kept parametric for the bench.

Ports:
- `clk`  in  1  system clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high; returns block to IDLE
- `start`  in  1  single-cycle request; sampled only in IDLE
- `a`  in  WIDTH  dividend (rs), signed two's complement; sampled with `start`
- `b`  in  WIDTH  divisor (rt), signed; sampled with `start`
- `lo`  out  WIDTH  quotient, registered
- `hi`  out  WIDTH  remainder, registered
- `busy`  out  1  high from the edge after `start` is accepted until `done`
- `done`  out  1  one-cycle pulse; `lo`/`hi`/`div_zero` valid from this cycle
- `div_zero`  out  1  registered; set with `done` when `b` was 0, cleared on next accepted `start`

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - `start`=1 and `b`≠0 -> latch `|a|`, `|b|`, `sign_q = a[31]^b[31]`, `sign_r = a[31]`; clear partial remainder; count=0; go RUN.
  - `start`=1 and `b`=0 -> set `div_zero`; `lo`/`hi` unchanged; go DONE.
- RUN, once per cycle:
  - Shift `{rem, quo}` left by 1.
  - If `rem_shifted >= |b|`, subtract `|b|` and set quotient LSB=1.
  - Increment count; after the iteration with count=31, go FIX.
  - Remainder datapath is WIDTH+1 bits to avoid overflow in the compare/subtract.
- FIX:
  - `lo = sign_q ? -quo : quo`; `hi = sign_r ? -rem : rem`.
  - Go DONE.
- DONE: `done`=1 for this cycle only; go IDLE.
- Arithmetic (MIPS semantics):
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - `|a|` of 0x80000000 is the unsigned magnitude 2^31, with no overflow.
  - 0x80000000 / -1 -> `lo`=0x80000000, `hi`=0. This falls out of the magnitude datapath; no special case.
- `start` in any state other than IDLE is ignored. Operands are not re-sampled.
- `a`/`b` may change after the accepting edge without effect.
- `lo`/`hi` hold their value until the next FIX.

## Timing
- Reset values: state=IDLE, `lo`=0, `hi`=0, `busy`=0, `done`=0, `div_zero`=0, count=0.
- Normal latency: `start` sampled at edge E -> `done` high in the cycle after edge E+33. That is 32 RUN cycles + 1 FIX + DONE entry.
- `busy` is high from E+1 through the `done` cycle inclusive.
- Divide-by-zero latency: `done` and `div_zero` high in the cycle after edge E+1.
- Back-to-back: a `start` in the cycle right after `done` (state IDLE) is accepted.
- Reset mid-operation: at the reset edge all outputs return to reset values and state returns to IDLE. A `start` asserted together with `reset` is ignored.
- Simultaneous `start` and `done`: impossible, since `done` occurs in DONE, not IDLE.

## Structure
- Shared package `div_pkg`:
  - state enum `div_state_t` (IDLE, RUN, FIX, DONE)
  - constant `DIV_ITER = 32`
  - counter width `DIV_CNT_W = 6`
- One sub-module, `div_step`: a purely combinational restoring step.
  - Inputs: `{rem, quo}` and `|b|`.
  - Outputs: next `{rem, quo}`.
  - Instantiated once in the RUN datapath.
- FSM, operand registers and sign fix stay in `div_unit`.

## Test plan
- a=100, b=7 -> `done` exactly 34 edges after `start`; `lo`=14, `hi`=2, `div_zero`=0.
- Sign cases, one line each:
  - a=-100, b=7 -> `lo`=0xFFFFFFF2 (-14), `hi`=0xFFFFFFFE (-2).
  - a=100, b=-7 -> `lo`=-14, `hi`=2.
  - a=-100, b=-7 -> `lo`=14, `hi`=-2.
- a=0x80000000, b=0xFFFFFFFF -> `lo`=0x80000000, `hi`=0. Then a=0x80000000, b=1 -> `lo`=0x80000000, `hi`=0.
- a=5, b=0 -> `done` and `div_zero` high 2 edges after `start`; `lo`/`hi` keep the previous result; next valid `start` clears `div_zero`.
- `start` with a=100, b=7, then re-pulse `start` with a=9, b=3 at cycle 10 -> ignored; result still 14/2.
- Assert `reset` at cycle 15 of a run -> all outputs 0, IDLE. A following 9/3 run gives `lo`=3, `hi`=0 on schedule.
